// File: rtl/multicycle_shifter_if.sv
// Handshake and data bundle for the multi-cycle universal shifter.
// The master side issues operations; the slave side is the shifter itself.
interface multicycle_shifter_if #(
  parameter int N  = 8,
  parameter int AW = $clog2(N)
);
  logic          start;
  logic [2:0]    op;
  logic [AW-1:0] amt;
  logic [N-1:0]  IN;
  logic          sin;
  logic [N-1:0]  OUT;
  logic          sout;
  logic          ready;
  logic          busy;
  logic          done;

  modport master (
    output start, op, amt, IN, sin,
    input  OUT, sout, ready, busy, done
  );

  modport slave (
    input  start, op, amt, IN, sin,
    output OUT, sout, ready, busy, done
  );
endinterface

// File: rtl/multicycle_shifter.sv
// N-bit universal shift register: logical/arithmetic/rotate/serial shifts of a
// programmable amount, one bit position per clock, with start/busy/done handshake.
module multicycle_shifter #(
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input logic                clk,
  input logic                rst,
  multicycle_shifter_if.slave bus
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_SIL  = 3'b110;
  localparam logic [2:0] OP_SIR  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q;
  logic [2:0]    op_q;
  logic [AW-1:0] cnt_q;
  logic [N-1:0]  out_q;
  logic          sout_q;
  logic [N:0]    step_d;

  // One 1-bit step of the given op; result packed as {bit shifted out, new value}.
  function automatic logic [N:0] shift_step(input logic [2:0]   op,
                                            input logic [N-1:0] v,
                                            input logic         s,
                                            input logic         cur_sout);
    case (op)
      OP_SLL:  return {v[N-1], v[N-2:0], 1'b0};
      OP_SRL:  return {v[0], 1'b0, v[N-1:1]};
      OP_SRA:  return {v[0], v[N-1], v[N-1:1]};
      OP_ROL:  return {v[N-1], v[N-2:0], v[N-1]};
      OP_ROR:  return {v[0], v[0], v[N-1:1]};
      OP_SIL:  return {v[N-1], v[N-2:0], s};
      OP_SIR:  return {v[0], s, v[N-1:1]};
      default: return {cur_sout, v};
    endcase
  endfunction

  always_comb begin
    step_d = shift_step(op_q, out_q, bus.sin, sout_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      cnt_q   <= '0;
      out_q   <= '0;
      sout_q  <= 1'b0;
    end else if (bus.start && state_q != S_RUN) begin
      // Accept edge: also taken from DONE so operations can run back-to-back.
      op_q  <= bus.op;
      cnt_q <= bus.amt;
      if (bus.op == OP_LOAD) begin
        out_q   <= bus.IN;
        state_q <= S_DONE;
      end else if (bus.amt == '0) begin
        state_q <= S_DONE;
      end else begin
        state_q <= S_RUN;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          {sout_q, out_q} <= step_d;
          cnt_q           <= cnt_q - 1'b1;
          if (cnt_q == AW'(1)) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.OUT   = out_q;
  assign bus.sout  = sout_q;
  assign bus.ready = (state_q != S_RUN);
  assign bus.busy  = (state_q == S_RUN);
  assign bus.done  = (state_q == S_DONE);

endmodule

// File: tb/tb_multicycle_shifter.sv
// Directed bench for multicycle_shifter: a vector table of shift operations
// plus hand-written sequences for the handshake and reset corner cases.
module tb_multicycle_shifter;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_SIL  = 3'b110;
  localparam logic [2:0] OP_SIR  = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multicycle_shifter_if #(.N(8)) bus ();

  multicycle_shifter #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  typedef struct packed {
    logic [7:0] pre;
    logic [2:0] op;
    logic [2:0] amt;
    logic [7:0] din;
    logic [7:0] eout;
    logic       esout;
  } vec_t;

  vec_t tbl [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for the DONE cycle; lat counts edges after accept.
  task automatic run_op(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] din,
                        output int lat);
    bus.start = 1'b1;
    bus.op    = op;
    bus.amt   = amt;
    bus.IN    = din;
    tick();
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    if (lat >= 40) lat = -1;
  endtask

  initial begin
    int lat;
    int d0;
    bus.start = 1'b0;
    bus.op    = OP_LOAD;
    bus.amt   = '0;
    bus.IN    = '0;
    bus.sin   = 1'b0;

    tbl[0]  = '{8'h0F, OP_SLL,  3'd3, 8'h00, 8'h78, 1'b0};
    tbl[1]  = '{8'h96, OP_SRA,  3'd2, 8'h00, 8'hE5, 1'b1};
    tbl[2]  = '{8'h96, OP_SRL,  3'd2, 8'h00, 8'h25, 1'b1};
    tbl[3]  = '{8'h0C, OP_SLL,  3'd0, 8'h00, 8'h0C, 1'b1};
    tbl[4]  = '{8'h81, OP_ROL,  3'd4, 8'h00, 8'h18, 1'b0};
    tbl[5]  = '{8'h18, OP_ROR,  3'd1, 8'h00, 8'h0C, 1'b0};
    tbl[6]  = '{8'h80, OP_SRA,  3'd7, 8'h00, 8'hFF, 1'b0};
    tbl[7]  = '{8'h01, OP_SRL,  3'd1, 8'h00, 8'h00, 1'b1};
    tbl[8]  = '{8'h00, OP_LOAD, 3'd5, 8'hA5, 8'hA5, 1'b1};
    tbl[9]  = '{8'h01, OP_SLL,  3'd7, 8'h00, 8'h80, 1'b0};
    tbl[10] = '{8'h01, OP_ROR,  3'd7, 8'h00, 8'h02, 1'b0};
    tbl[11] = '{8'h80, OP_SIR,  3'd3, 8'h00, 8'h10, 1'b0};

    tick();
    tick();
    rst = 1'b0;
    chk("reset OUT",   bus.OUT,   8'h00);
    chk("reset sout",  bus.sout,  1'b0);
    chk("reset ready", bus.ready, 1'b1);
    chk("reset busy",  bus.busy,  1'b0);
    chk("reset done",  bus.done,  1'b0);

    // LOAD 0x0F then SLL 3, watching every edge.
    d0 = done_cnt;
    bus.start = 1'b1; bus.op = OP_LOAD; bus.IN = 8'h0F; bus.amt = 3'd0;
    tick();
    bus.start = 1'b0;
    chk("load OUT",  bus.OUT,  8'h0F);
    chk("load done", bus.done, 1'b1);
    chk("load busy", bus.busy, 1'b0);
    tick();
    chk("load done clears", bus.done, 1'b0);
    chk("load busy idle",   bus.busy, 1'b0);
    chk("load one pulse",   done_cnt - d0, 1);
    bus.start = 1'b1; bus.op = OP_SLL; bus.amt = 3'd3;
    tick();
    bus.start = 1'b0;
    chk("sll E0 busy", bus.busy, 1'b1);
    chk("sll E0 OUT",  bus.OUT,  8'h0F);
    tick();
    chk("sll E1 OUT",  bus.OUT,  8'h1E);
    chk("sll E1 busy", bus.busy, 1'b1);
    tick();
    chk("sll E2 OUT",  bus.OUT,  8'h3C);
    tick();
    chk("sll E3 OUT",  bus.OUT,  8'h78);
    chk("sll E3 done", bus.done, 1'b1);
    chk("sll E3 busy", bus.busy, 1'b0);
    chk("sll sout",    bus.sout, 1'b0);
    tick();
    chk("sll done clears", bus.done,  1'b0);
    chk("sll ready",       bus.ready, 1'b1);

    for (int i = 0; i < 12; i++) begin
      run_op(OP_LOAD, 3'd0, tbl[i].pre, lat);
      tick();
      run_op(tbl[i].op, tbl[i].amt, tbl[i].din, lat);
      chk($sformatf("vec%0d OUT", i),  bus.OUT,  tbl[i].eout);
      chk($sformatf("vec%0d sout", i), bus.sout, tbl[i].esout);
      chk($sformatf("vec%0d latency", i), lat,
          (tbl[i].op == OP_LOAD) ? 0 : int'(tbl[i].amt));
      tick();
    end

    // SIL with serial bits 1,0,1 and a start pulsed mid-run.
    run_op(OP_LOAD, 3'd0, 8'h00, lat);
    tick();
    bus.start = 1'b1; bus.op = OP_SIL; bus.amt = 3'd3;
    tick();
    bus.sin = 1'b1; bus.op = OP_LOAD; bus.IN = 8'hFF; bus.amt = 3'd1;
    tick();
    bus.start = 1'b0;
    chk("sil E1 OUT", bus.OUT, 8'h01);
    bus.sin = 1'b0;
    tick();
    chk("sil E2 OUT", bus.OUT, 8'h02);
    bus.sin = 1'b1;
    tick();
    chk("sil E3 OUT",  bus.OUT,  8'h05);
    chk("sil done",    bus.done, 1'b1);
    chk("sil sout",    bus.sout, 1'b0);
    bus.sin = 1'b0;
    tick();
    chk("sil no queued op", bus.done, 1'b0);
    chk("sil OUT holds",    bus.OUT,  8'h05);

    // Reset during an SLL 7 run aborts without a done pulse.
    run_op(OP_LOAD, 3'd0, 8'h01, lat);
    tick();
    bus.start = 1'b1; bus.op = OP_SLL; bus.amt = 3'd7;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    chk("abort partial OUT", bus.OUT, 8'h08);
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort OUT",   bus.OUT,   8'h00);
    chk("abort ready", bus.ready, 1'b1);
    chk("abort busy",  bus.busy,  1'b0);
    chk("abort done",  bus.done,  1'b0);
    for (int i = 0; i < 8; i++) tick();
    chk("abort no done pulse", done_cnt - d0, 0);

    // Back-to-back: SLL 2 accepted in the DONE cycle of a LOAD.
    d0 = done_cnt;
    bus.start = 1'b1; bus.op = OP_LOAD; bus.IN = 8'h01; bus.amt = 3'd0;
    tick();
    chk("b2b load done", bus.done, 1'b1);
    chk("b2b load OUT",  bus.OUT,  8'h01);
    bus.op = OP_SLL; bus.amt = 3'd2;
    tick();
    bus.start = 1'b0;
    chk("b2b sll busy", bus.busy, 1'b1);
    chk("b2b sll done", bus.done, 1'b0);
    tick();
    chk("b2b E1 OUT", bus.OUT, 8'h02);
    tick();
    chk("b2b E2 OUT",  bus.OUT,  8'h04);
    chk("b2b E2 done", bus.done, 1'b1);
    tick();
    chk("b2b two pulses", done_cnt - d0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_shifter.md
# multicycle_shifter

Parametrised successor to the team's 2-bit-select shift register with parallel load. It is an N-bit universal shift register that runs logical, arithmetic, rotate and serial-in shifts of a programmable amount, one bit position per clock. A start/busy/done handshake lets a controller FSM issue operations and wait for completion. It sits in the datapath as the register-file-side shifter for multi-bit shift instructions.

## Interface
- N, default 8: register width, N ≥ 2.
- AW, default $clog2(N): width of the shift-amount port; amounts 0..N-1.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- op  in  3  operation: 000 LOAD, 001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR, 110 SIL (serial in at LSB, shift left), 111 SIR (serial in at MSB, shift right).
- amt  in  AW  shift count; ignored for LOAD.
- IN  in  N  parallel load data.
- sin  in  1  serial input bit for SIL/SIR, sampled on every shift edge.
- OUT  out  N  register contents.
- sout  out  1  last bit shifted out of the register.
- ready  out  1  high when a start will be accepted.
- busy  out  1  high while shifting.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE. ready = (state != RUN). busy = (state == RUN). done = (state == DONE).
- Accept edge (start=1, ready=1): latch op and amt into internal registers.
  - LOAD: OUT ← IN and go to DONE.
  - amt = 0 (any shift op): OUT unchanged and go to DONE.
  - Otherwise: cnt ← amt and go to RUN.
- RUN, each edge: apply one 1-bit step of the latched op, then cnt ← cnt-1. When cnt reaches 0 after a step, go to DONE.
  - SLL: shift left, LSB ← 0. sout ← old MSB.
  - SRL: shift right, MSB ← 0. sout ← old LSB.
  - SRA: shift right, MSB ← old MSB. sout ← old LSB.
  - ROL: rotate left; ROR: rotate right. sout ← the bit that wrapped.
  - SIL: shift left, LSB ← sin. sout ← old MSB.
  - SIR: shift right, MSB ← sin. sout ← old LSB.
- DONE: lasts one cycle, then IDLE. A start in DONE is accepted, giving back-to-back operations; that edge follows the accept-edge rules above.
- start while busy=1: ignored. It is not queued, and op, amt and IN changes have no effect.
- OUT holds its value in IDLE and DONE. Only LOAD and shift steps modify it.
- sout changes only on shift steps. LOAD and amt=0 leave it unchanged.
- Reset at any edge: OUT=0, sout=0, state=IDLE, cnt=0. Reset overrides start and aborts an in-flight RUN with no done pulse. After reset, ready=1, busy=0, done=0.

## Timing
- Accept at edge E0.
- LOAD or amt=0: done=1 in the cycle after E0. A LOAD shows OUT=IN from E0.
- Shift of k ≥ 1 positions:
  - busy=1 from E0 to Ek.
  - OUT shows the partial result after each edge E1..Ek.
  - done=1 for the cycle after Ek; total latency k+1 cycles to done.
- Back-to-back: a start accepted in the DONE cycle makes that same edge the new E0. No idle cycle is needed.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.

## Test plan
- Reset, then LOAD IN=0x0F → OUT=0x0F after the accept edge; done pulses exactly once; busy never rises. Then SLL amt=3 → busy 3 cycles, OUT 0x1E, 0x3C, 0x78; done one cycle; sout=0.
- LOAD 0x96, SRA amt=2 → OUT=0xE5, sout=1. LOAD 0x96, SRL amt=2 → OUT=0x25, sout=1.
- LOAD 0x81, ROL amt=4 → OUT=0x18. Then ROR amt=1 → OUT=0x0C, sout=0. Then SLL amt=0 → done the next cycle, OUT unchanged at 0x0C.
- LOAD 0x00, SIL amt=3 with sin=1,0,1 on successive shift edges → OUT=0x05. A start pulsed mid-RUN is ignored and the result is unchanged.
- Begin SLL amt=7 on 0x01; assert rst after 3 shift edges → OUT=0, ready=1, no done pulse.
- Back-to-back: issue LOAD 0x01, then SLL amt=2 in the DONE cycle → OUT=0x04; done pulses twice, with no idle cycle between the two operations.
